// File: rtl/yacht_pkg.sv
// yacht_pkg: shared dice count, turn limits and roll-controller state encoding
package yacht_pkg;
  localparam int NUM_DICE = 5;
  localparam int MAX_ROLLS = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_ROLL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise a raw button, accept level changes stable for DEBOUNCE_CYC cycles, pulse on press
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = (s2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
  // sync chain, mismatch counter, accepted level and registered rising-edge pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      cnt <= (s2 == level || hit) ? '0 : cnt + 1'b1;
      level <= hit ? s2 : level;
      press <= hit && s2;
    end
  end
endmodule

// File: rtl/yacht_roll_ctrl.sv
// yacht_roll_ctrl: debounced roll button plus turn FSM driving roll_en and hold_mask into the dice manager
module yacht_roll_ctrl
  import yacht_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int ROLL_CYC = 12_500_000,
  parameter int MAX_ROLLS = yacht_pkg::MAX_ROLLS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                roll_btn,
  input  logic [NUM_DICE-1:0] hold_sw,
  input  logic                turn_start,
  input  logic                commit,
  output logic                roll_en,
  output logic [NUM_DICE-1:0] hold_mask,
  output logic [1:0]          roll_cnt,
  output logic                can_roll,
  output logic                roll_done,
  output logic                turn_over
);
  localparam int TW = (ROLL_CYC > 1) ? $clog2(ROLL_CYC) : 1;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic press;
  logic btn_level;
  logic [1:0] cnt_inc;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk(clk),
    .reset_n(reset_n),
    .btn(roll_btn),
    .level(btn_level),
    .press(press)
  );
  // a full hold after the first roll would be a wasted roll, so it is refused
  assign can_roll = (state == S_READY) && !(roll_cnt != 2'd0 && &hold_sw);
  assign cnt_inc = (roll_cnt == 2'(MAX_ROLLS)) ? roll_cnt : roll_cnt + 2'd1;
  // turn FSM: accept rolls, time the spin, count rolls, end the turn
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      timer <= '0;
      roll_en <= 1'b0;
      hold_mask <= '0;
      roll_cnt <= 2'd0;
      roll_done <= 1'b0;
      turn_over <= 1'b0;
    end else begin
      roll_done <= 1'b0;
      case (state)
        S_IDLE: if (turn_start) begin
          state <= S_READY;
          roll_cnt <= 2'd0;
        end
        S_READY: if (commit && roll_cnt != 2'd0) begin
          state <= S_DONE;
          turn_over <= 1'b1;
        end else if (press && can_roll) begin
          state <= S_ROLL;
          roll_en <= 1'b1;
          timer <= '0;
          hold_mask <= (roll_cnt == 2'd0) ? '0 : hold_sw;
        end
        S_ROLL: if (timer == TW'(ROLL_CYC - 1)) begin
          roll_en <= 1'b0;
          roll_done <= 1'b1;
          roll_cnt <= cnt_inc;
          state <= (cnt_inc == 2'(MAX_ROLLS)) ? S_DONE : S_READY;
          turn_over <= (cnt_inc == 2'(MAX_ROLLS));
        end else begin
          timer <= timer + 1'b1;
        end
        S_DONE: if (turn_start) begin
          state <= S_READY;
          roll_cnt <= 2'd0;
          hold_mask <= '0;
          turn_over <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
